// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sharing controller: opcodes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Two-port request/response bundle between the requesters and the shared-ALU controller.
interface alu_share_ctrl_if;

  // Valid/ready on both channels: a transfer happens on a rising edge where valid and
  // ready are both high; the source holds valid and its payload stable until then.
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [2:0]  op0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic [2:0]  op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] result;

  modport master (
    output req_valid, a0, b0, op0, a1, b1, op1, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, a0, b0, op0, a1, b1, op1, resp_ready,
    output req_ready, resp_valid, result
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit unsigned ALU; shifts by 32 or more produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD, OP_ADDI: result_o = a_i + b_i;
      OP_SUBI:         result_o = a_i - b_i;
      OP_EQ:           result_o = {31'd0, (a_i == b_i)};
      OP_SHL:          result_o = (b_i >= 32'd32) ? '0 : (a_i << b_i[4:0]);
      OP_SHR:          result_o = (b_i >= 32'd32) ? '0 : (a_i >> b_i[4:0]);
      default:         result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two requesters, with registered operands,
// a programmable execute dwell, and a held response until the owner accepts it.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic             busy,
  output state_t           dbg_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15 || (1 << CNT_W) <= EXEC_CYCLES) begin : g_bad_params
    $error("alu_share_ctrl: illegal EXEC_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [2:0]       opc_q, opc_d;
  logic [31:0]      result_q, result_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [1:0]       grant;
  logic [31:0]      alu_result;

  // Only the latched operands reach the ALU, so live port inputs cannot disturb EXEC.
  alu u_alu (
    .a_i      (opa_q),
    .b_i      (opb_q),
    .op_i     (opc_q),
    .result_o (alu_result)
  );

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == ST_IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opc_d        = opc_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          opa_d   = grant[1] ? bus.a1  : bus.a0;
          opb_d   = grant[1] ? bus.b1  : bus.b0;
          opc_d   = grant[1] ? bus.op1 : bus.op0;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          result_d     = alu_result;
          resp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      result_q     <= '0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.result     = result_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state_o    = state_q;
  assign dbg_cnt_o      = cnt_q;

  a_resp_onehot: assert property (@(posedge clk) disable iff (rst) bus.resp_valid != 2'b11);
  a_req_onehot:  assert property (@(posedge clk) disable iff (rst) bus.req_ready != 2'b11);
  a_req_idle:    assert property (@(posedge clk) disable iff (rst)
                                  (bus.req_ready != 2'b00) |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized scoreboard bench for alu_share_ctrl plus a directed EXEC_CYCLES=3 instance.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int EXEC = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT (default timing) ----------------
  alu_share_ctrl_if bus ();
  logic        v [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic [2:0]  opv [2];
  logic [1:0]  rr = 2'b11;
  int          rr_mode = 0;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_cnt;

  assign bus.req_valid  = {v[1], v[0]};
  assign bus.a0         = av[0];
  assign bus.b0         = bv[0];
  assign bus.op0        = opv[0];
  assign bus.a1         = av[1];
  assign bus.b1         = bv[1];
  assign bus.op1        = opv[1];
  assign bus.resp_ready = rr;

  alu_share_ctrl #(.EXEC_CYCLES(EXEC), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_cnt_o   (dbg_cnt)
  );

  // ---------------- DUT (three-cycle dwell) ----------------
  alu_share_ctrl_if bus3 ();
  logic        v3 = 1'b0;
  logic [31:0] a3 = '0;
  logic [31:0] b3 = '0;
  logic [2:0]  op3 = '0;
  logic        busy3;
  logic [1:0]  state3;
  logic [3:0]  cnt3;

  assign bus3.req_valid  = {1'b0, v3};
  assign bus3.a0         = a3;
  assign bus3.b0         = b3;
  assign bus3.op0        = op3;
  assign bus3.a1         = '0;
  assign bus3.b1         = '0;
  assign bus3.op1        = '0;
  assign bus3.resp_ready = 2'b11;

  alu_share_ctrl #(.EXEC_CYCLES(3), .CNT_W(4)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus3),
    .busy        (busy3),
    .dbg_state_o (state3),
    .dbg_cnt_o   (cnt3)
  );

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference ALU written straight from the opcode table with plain arithmetic.
  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [63:0] wide;
    case (op)
      3'b010, 3'b110: return a + b;
      3'b111:         return a - b;
      3'b011:         return (a == b) ? 32'd1 : 32'd0;
      3'b100: begin
        if (b >= 32) return 32'd0;
        wide = {32'd0, a} << b;
        return wide[31:0];
      end
      3'b101: begin
        if (b >= 32) return 32'd0;
        return a >> b;
      end
      default:        return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];   // {port, result} in service order
  int          acc_q[$];   // accept cycle of each queued transaction
  bit          outstanding = 0;
  bit          last_served = 1'b1;
  bit          resp_seen = 0;
  bit          pend_at_hs = 0;
  int          hs_cyc = 0;

  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [32:0] head;
    bit          p;
    bit          clr;
    clr = 0;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      outstanding = 0;
      last_served = 1'b1;
      resp_seen   = 0;
      pend_at_hs  = 0;
    end else begin
      chk("busy", busy, outstanding);

      // Transaction-level arbitration model: grant only when nothing is in flight.
      if (bus.req_valid == 2'b11) eg = last_served ? 2'b01 : 2'b10;
      else                        eg = bus.req_valid;
      if (outstanding) eg = 2'b00;
      chk("grant", bus.req_ready, eg);

      if (bus.resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_resp actual=%b required=00 (cycle %0d)", bus.resp_valid, cyc);
        end else begin
          head = exp_q[0];
          p    = head[32];
          chk("resp_port", bus.resp_valid, p ? 2'b10 : 2'b01);
          chk("resp_result", bus.result, head[31:0]);
          if (!resp_seen) chk("resp_latency", cyc, acc_q[0] + EXEC + 1);
          resp_seen = 1;
          if (bus.resp_ready[p]) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            last_served = p;
            hs_cyc      = cyc;
            pend_at_hs  = (bus.req_valid != 2'b00);
            resp_seen   = 0;
            clr         = 1;
          end
        end
      end else if (outstanding) begin
        chk("resp_timely", (cyc >= acc_q[0] + EXEC + 1) ? 32'd1 : 32'd0, 32'd0);
      end

      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back({i[0], ref_alu(i == 1 ? bus.a1 : bus.a0,
                                         i == 1 ? bus.b1 : bus.b0,
                                         i == 1 ? bus.op1 : bus.op0)});
          acc_q.push_back(cyc);
          if (pend_at_hs) chk("idle_gap", cyc, hs_cyc + 1);
          pend_at_hs  = 0;
          outstanding = 1;
          clr         = 0;
        end
      end
      if (clr) outstanding = 0;
    end
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       rr = 2'b11;
      1:       rr = 2'($urandom_range(0, 3));
      default: rr = 2'b00;
    endcase
  end

  // Present a request and hold it until accepted; scramble operands afterwards so a
  // design that reads live inputs during EXEC would compute the wrong value.
  task automatic send(int p, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    bit got;
    got    = 0;
    av[p]  = a;
    bv[p]  = b;
    opv[p] = op;
    v[p]   = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (!rst && bus.req_ready[p]) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout port=%0d actual=no_grant required=grant", p);
    end
    @(posedge clk);
    #1;
    v[p]   = 1'b0;
    av[p]  = $urandom;
    bv[p]  = $urandom;
    opv[p] = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_port(int p, int n, int max_gap);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(p, a, b, 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((outstanding || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; av[i] = '0; bv[i] = '0; opv[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_cnt", dbg_cnt, 0);
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_result", bus.result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result3", bus3.result, 0);
    @(posedge clk);
    #1;

    // Single request.
    send(0, 32'd5, 32'd7, OP_ADD);
    wait_idle();

    // Contention from reset, then continuous contention.
    rst = 1'b1;
    fork
      send(0, 32'd1, 32'd1, OP_ADD);
      send(1, 32'd10, 32'd3, OP_SUBI);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    fork
      rand_port(0, 8, 0);
      rand_port(1, 8, 0);
    join
    wait_idle();

    // Backpressure on port 1 while port 0 waits.
    rr_mode = 2;
    fork
      send(1, 32'h8000_0000, 32'd4, OP_SHR);
      begin
        @(posedge clk);
        #1;
        send(0, $urandom, $urandom, OP_ADD);
      end
      begin
        for (int n = 0; n < 50 && !bus.resp_valid[1]; n++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        rr_mode = 0;
      end
    join
    wait_idle();

    // Boundary operands and opcodes.
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_EQ);
    send(1, 32'hFFFF_FFFF, 32'd1, OP_ADD);
    send(0, 32'd1, 32'd32, OP_SHL);
    send(1, $urandom, $urandom, 3'b000);
    send(0, 32'h8000_0000, 32'd31, OP_SHR);
    send(1, 32'd0, 32'd1, OP_SUBI);
    send(0, 32'd3, 32'd3, 3'b001);
    send(1, 32'hDEAD_BEEF, 32'd33, OP_SHR);
    wait_idle();

    // Random traffic with random response backpressure.
    rr_mode = 1;
    fork
      rand_port(0, 40, 4);
      rand_port(1, 40, 4);
    join
    rr_mode = 0;
    wait_idle();

    // Reset one cycle after accept: the op is dropped.
    send(0, 32'd100, 32'd23, OP_ADD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_resp_valid", bus.resp_valid, 2'b00);
    chk("mid_rst_result", bus.result, 0);
    repeat (4) @(posedge clk);
    #1;
    send(1, 32'd9, 32'd4, OP_SUBI);
    wait_idle();

    // Three-cycle dwell instance.
    a3  = 32'd2;
    b3  = 32'd3;
    op3 = OP_ADD;
    v3  = 1'b1;
    @(negedge clk);
    chk("x3_ready", bus3.req_ready, 2'b01);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    a3 = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("x3_state", state3, ST_EXEC);
      chk("x3_cnt", cnt3, k);
      chk("x3_resp_valid", bus3.resp_valid, 2'b00);
    end
    @(negedge clk);
    chk("x3_resp_valid_on", bus3.resp_valid, 2'b01);
    chk("x3_result", bus3.result, ref_alu(32'd2, 32'd3, OP_ADD));
    chk("x3_busy", busy3, 1);
    @(negedge clk);
    chk("x3_back_idle", state3, ST_IDLE);
    chk("x3_resp_cleared", bus3.resp_valid, 2'b00);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
